// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register enables/flushes for freezes, branches, load-use and halt/drain.
module pipe_hazard_ctrl #(
  parameter int BR_PENALTY = 1,
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, BRFLUSH, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [3:0] pen_q, pen_d;
  logic [1:0] drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu, stall;
  assign lu = ex_is_load & ex_rd != '0 &
              ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd));
  always_comb begin
    state_d = state_q;
    pen_d = pen_q;
    drain_d = drain_q;
    {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
    {flush_ifid, flush_idex, halted, stall} = '0;
    if (state_q == HALT) begin
      {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '0;
      halted = 1'b1;
      state_d = resume ? RUN : HALT;
    end else if (mem_busy) begin
      {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '0;
      stall = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (br_taken) begin
            {flush_ifid, flush_idex} = 2'b11;
            if (BR_PENALTY > 0) begin
              state_d = BRFLUSH;
              pen_d = 4'(BR_PENALTY);
            end
          end else if (lu) begin
            {pc_en, en_ifid, flush_idex, stall} = 4'b0011;
          end else if (halt_req) begin
            state_d = DRAIN;
            drain_d = 2'd3;
          end
        end
        BRFLUSH: begin
          flush_ifid = 1'b1;
          pen_d = pen_q - 4'd1;
          state_d = pen_q == 4'd1 ? RUN : BRFLUSH;
        end
        DRAIN: begin
          {pc_en, en_ifid, flush_idex, stall} = 4'b0011;
          drain_d = drain_q - 2'd1;
          state_d = drain_q == 2'd1 ? HALT : DRAIN;
        end
        default: ;
      endcase
    end
    // reset must hold the pipeline frozen with bubbles regardless of state
    if (!rst_n) begin
      {pc_en, en_ifid, en_idex, en_exmem, en_memwb, halted} = '0;
      {flush_ifid, flush_idex} = 2'b11;
    end
  end
  assign cnt_d = cnt_clr ? '0 : (stall & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  assign stall_cnt = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pen_q <= '0;
      drain_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pen_q <= pen_d;
      drain_q <= drain_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
